sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares one single-port, 1-cycle-read-latency SRAM between the CPU pipeline's instruction-fetch requester and its load/store requester.
- Sits between mycpu_pipeline's inst/data SRAM ports and a unified memory.
- Data has priority over instruction fetch, and a starvation counter bounds the fetch wait.
- Routes each read response back to the requester that issued it, with an optional fetch-response cancel on pipeline flush.

Parameters:
- ADDR_W, 32, address width of both requesters and the SRAM.
- DATA_W, 32, data width; write-enable width is DATA_W/8.
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced; range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held until granted.
- i_we  in  DATA_W/8  fetch byte write enables (normally 0).
- i_addr  in  ADDR_W  fetch address.
- i_wdata  in  DATA_W  fetch write data.
- i_flush  in  1  cancel the fetch response due next cycle.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch response valid.
- i_rdata  out  DATA_W  fetch read data.
- d_req, d_we, d_addr, d_wdata  in  same as i_*  data requester.
- d_gnt, d_rvalid, d_rdata  out  same as i_*  data requester.
- sram_en  out  1  SRAM access enable.
- sram_we  out  DATA_W/8  SRAM byte write enables.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after sram_en with sram_we==0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - starve_cnt=0, resp_owner=NONE, resp_is_read=0.
  - All gnt and rvalid outputs are 0 and all rdata outputs are 0 while reset is asserted; a request present during reset is not granted.
  - An in-flight response at reset assertion is dropped.
- Grant is combinational in the same cycle as the request; at most one grant per cycle:
  - Only d_req → data.
  - Only i_req → inst.
  - Both, starve_cnt<STARVE_MAX → data.
  - Both, starve_cnt==STARVE_MAX → inst.
  - Neither → no grant; sram_en=0, and sram_we/addr/wdata=0.
- SRAM outputs mux the granted requester's we/addr/wdata; sram_en=i_gnt|d_gnt.
- starve_cnt is updated at the clock edge:
  - Increments when d_gnt & i_req, saturating at STARVE_MAX.
  - Clears to 0 when i_gnt, or when i_req=0.
- Response stage (registered owner, 1-cycle latency):
  - At the edge, resp_owner is set to the granter (INST/DATA/NONE).
  - resp_is_read is set to (granted we==0).
  - Next cycle, the owner's rvalid=1.
  - rdata=sram_rdata for reads; rdata=0 for writes, where rvalid serves as the write ack.
  - The non-owner's rvalid=0 and rdata=0.
- i_flush=1 in the cycle i_rvalid would assert forces i_rvalid=0 and i_rdata=0; data responses are unaffected.
- i_flush in a grant cycle does not cancel that grant.
- Back-to-back grants every cycle are supported, so throughput is 1 access/cycle.
- Requesters must hold req/we/addr/wdata stable until gnt; a dropped request is simply not served.
- Boundary cases:
  - STARVE_MAX=1 alternates data/inst when both request continuously.
  - A counter already at STARVE_MAX when i_req drops clears to 0.
  - Simultaneous inst forced-grant and data request: data waits one cycle, and its response ordering is preserved.

Decomposition:
- Shared package (mem_arb_pkg):
  - owner_t enum: OWN_NONE=2'd0, OWN_INST=2'd1, OWN_DATA=2'd2.
  - Localparam STARVE_W=4.
- Sub-module sram_arb_prio: combinational grant decision plus the starve_cnt register, taking i_req, d_req, clk and rst_n.
- The top level holds the mux and the response stage.

Test Plan:
1. Reset assertion: hold rst_n=0 with i_req=d_req=1 → i_gnt=d_gnt=0, sram_en=0, all rvalid=0. Release, then d_req=1 with addr 0x100, we=0, SRAM returns 0xDEADBEEF → d_gnt same cycle, d_rvalid=1 next cycle with d_rdata=0xDEADBEEF, i_rvalid=0.
2. Data priority: both request continuously, STARVE_MAX=4 → grant sequence D,D,D,D,I,D,D,D,D,I. starve_cnt returns to 0 after each I.
3. Mixed write/read: d write to 0x200 (we=4'hF, wdata=0x12345678), then i read of 0x200 → d_rvalid=1 with d_rdata=0; next cycle i_rvalid=1 with i_rdata=0x12345678.
4. Fetch flush: i read granted, i_flush=1 the following cycle → i_rvalid=0. A d read granted in that flush cycle still gets d_rvalid=1 the cycle after.
5. Reset mid-operation: d read granted, rst_n pulsed low before the response edge → d_rvalid stays 0. After release, starve_cnt=0, so a first both-request cycle grants data.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the SRAM arbiter slice: response-owner encoding and
// the width of the fetch starvation counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/sram_arb_prio.sv
// Grant decision between fetch and data requesters: data wins unless fetch
// has waited through STARVE_MAX consecutive data grants.
module sram_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic d_req,
    output logic i_gnt,
    output logic d_gnt
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    localparam logic [STARVE_W-1:0] CNT_ONE    = STARVE_W'(1);

    logic [STARVE_W-1:0] starve_cnt_r;
    logic                force_inst_s;

    assign force_inst_s = (starve_cnt_r == STARVE_LIM);

    // Same-cycle grant; nothing is granted while reset is held.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst_n) begin
            i_gnt = 1'b0;
            d_gnt = 1'b0;
        end else if (d_req && !(i_req && force_inst_s)) begin
            d_gnt = 1'b1;
        end else if (i_req) begin
            i_gnt = 1'b1;
        end else begin
            i_gnt = 1'b0;
            d_gnt = 1'b0;
        end
    end

    // Counts data grants that bypassed a waiting fetch, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else if (i_gnt || !i_req) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else if (d_gnt && (starve_cnt_r != STARVE_LIM)) begin
            starve_cnt_r <= starve_cnt_r + CNT_ONE;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port, 1-cycle-latency SRAM between instruction fetch and
// load/store, routing each response back to the requester that issued it.
module sram_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [DATA_W/8-1:0] i_we,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic                i_flush,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic [DATA_W/8-1:0] d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    localparam int WE_W = DATA_W / 8;

    owner_t resp_owner_r;
    logic   resp_is_read_r;

    sram_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (i_req),
        .d_req (d_req),
        .i_gnt (i_gnt),
        .d_gnt (d_gnt)
    );

    // Drive the SRAM from whichever requester holds the grant; idle bus is zero.
    always_comb begin
        sram_en    = i_gnt | d_gnt;
        sram_we    = {WE_W{1'b0}};
        sram_addr  = {ADDR_W{1'b0}};
        sram_wdata = {DATA_W{1'b0}};
        if (d_gnt) begin
            sram_we    = d_we;
            sram_addr  = d_addr;
            sram_wdata = d_wdata;
        end else if (i_gnt) begin
            sram_we    = i_we;
            sram_addr  = i_addr;
            sram_wdata = i_wdata;
        end else begin
            sram_we    = {WE_W{1'b0}};
            sram_addr  = {ADDR_W{1'b0}};
            sram_wdata = {DATA_W{1'b0}};
        end
    end

    // Remember who owns the response arriving next cycle and whether it carries data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_owner_r   <= OWN_NONE;
            resp_is_read_r <= 1'b0;
        end else if (d_gnt) begin
            resp_owner_r   <= OWN_DATA;
            resp_is_read_r <= (d_we == {WE_W{1'b0}});
        end else if (i_gnt) begin
            resp_owner_r   <= OWN_INST;
            resp_is_read_r <= (i_we == {WE_W{1'b0}});
        end else begin
            resp_owner_r   <= OWN_NONE;
            resp_is_read_r <= 1'b0;
        end
    end

    // Route the response; a write completes with rvalid and zero data, and a
    // fetch response is squashed by a flush in its own cycle.
    always_comb begin
        i_rvalid = 1'b0;
        i_rdata  = {DATA_W{1'b0}};
        d_rvalid = 1'b0;
        d_rdata  = {DATA_W{1'b0}};
        case (resp_owner_r)
            OWN_INST: begin
                if (!i_flush) begin
                    i_rvalid = 1'b1;
                    i_rdata  = resp_is_read_r ? sram_rdata : {DATA_W{1'b0}};
                end else begin
                    i_rvalid = 1'b0;
                    i_rdata  = {DATA_W{1'b0}};
                end
            end
            OWN_DATA: begin
                d_rvalid = 1'b1;
                d_rdata  = resp_is_read_r ? sram_rdata : {DATA_W{1'b0}};
            end
            default: begin
                i_rvalid = 1'b0;
                d_rvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Table-driven bench for sram_arbiter with a response scoreboard and a
// behavioural SRAM model.
module tb_sram_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int WW   = 4;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, i_flush, d_req;
    logic [WW-1:0] i_we, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] i_wdata, d_wdata;
    logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          sram_en;
    logic [WW-1:0] sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    typedef struct {
        logic          ir;
        logic [WW-1:0] iwe;
        logic [AW-1:0] ia;
        logic [DW-1:0] iwd;
        logic          ifl;
        logic          dr;
        logic [WW-1:0] dwe;
        logic [AW-1:0] da;
        logic [DW-1:0] dwd;
        logic          egi;
        logic          egd;
    } vec_t;

    typedef struct {
        logic [1:0]    owner;
        logic          is_read;
        logic [DW-1:0] data;
    } resp_t;

    vec_t          vecs[$];
    resp_t         sb[$];
    logic [DW-1:0] ref_mem  [256];
    logic [DW-1:0] sram_mem [256];
    int            total;
    int            bad;
    int            vec_no;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_flush(i_flush), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    function automatic vec_t mk(input logic ir, input logic [WW-1:0] iwe,
                                input logic [AW-1:0] ia, input logic [DW-1:0] iwd,
                                input logic ifl, input logic dr, input logic [WW-1:0] dwe,
                                input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                                input logic egi, input logic egd);
        vec_t v;
        v.ir = ir; v.iwe = iwe; v.ia = ia; v.iwd = iwd; v.ifl = ifl;
        v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
        v.egi = egi; v.egd = egd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL vec%0d %s: got %h expected %h", vec_no, nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        i_req = v.ir; i_we = v.iwe; i_addr = v.ia; i_wdata = v.iwd; i_flush = v.ifl;
        d_req = v.dr; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd;
    endtask

    task automatic check_resp(input logic flush);
        resp_t e;
        logic  exp_iv;
        e.owner = 2'd0; e.is_read = 1'b0; e.data = 32'h0;
        if (sb.size() > 0) e = sb.pop_front();
        exp_iv = (e.owner == 2'd1) && !flush;
        chk("i_rvalid", {31'h0, i_rvalid}, {31'h0, exp_iv});
        chk("i_rdata", i_rdata, (exp_iv && e.is_read) ? e.data : 32'h0);
        chk("d_rvalid", {31'h0, d_rvalid}, {31'h0, (e.owner == 2'd2)});
        chk("d_rdata", d_rdata, ((e.owner == 2'd2) && e.is_read) ? e.data : 32'h0);
    endtask

    task automatic check_grant(input vec_t v);
        resp_t         e;
        logic [WW-1:0] we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        we = 4'h0; a = 32'h0; wd = 32'h0;
        if (v.egd) begin
            we = v.dwe; a = v.da; wd = v.dwd;
        end else if (v.egi) begin
            we = v.iwe; a = v.ia; wd = v.iwd;
        end
        chk("i_gnt", {31'h0, i_gnt}, {31'h0, v.egi});
        chk("d_gnt", {31'h0, d_gnt}, {31'h0, v.egd});
        chk("sram_en", {31'h0, sram_en}, {31'h0, (v.egi | v.egd)});
        chk("sram_we", {28'h0, sram_we}, {28'h0, we});
        chk("sram_addr", sram_addr, a);
        chk("sram_wdata", sram_wdata, wd);
        e.owner   = v.egd ? 2'd2 : (v.egi ? 2'd1 : 2'd0);
        e.is_read = (v.egi | v.egd) && (we == 4'h0);
        e.data    = e.is_read ? ref_mem[a[9:2]] : 32'h0;
        sb.push_back(e);
        if ((v.egi | v.egd) && (we != 4'h0)) begin
            for (int b = 0; b < WW; b++)
                if (we[b]) ref_mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    task automatic step(input vec_t v);
        logic          en;
        logic [WW-1:0] we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        drive(v);
        @(negedge clk);
        check_resp(v.ifl);
        check_grant(v);
        en = sram_en; we = sram_we; a = sram_addr; wd = sram_wdata;
        @(posedge clk);
        // SRAM model: read data appears right after the access edge.
        if (en) begin
            if (we == 4'h0) sram_rdata = sram_mem[a[9:2]];
            else
                for (int b = 0; b < WW; b++)
                    if (we[b]) sram_mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
        end
        #1;
        vec_no++;
    endtask

    initial begin
        vec_t idle, both;
        total = 0; bad = 0; vec_no = 0;
        sram_rdata = 32'h0;
        for (int k = 0; k < 256; k++) begin
            ref_mem[k]  = 32'hA500_0000 | k;
            sram_mem[k] = 32'hA500_0000 | k;
        end
        ref_mem[64]  = 32'hDEAD_BEEF;
        sram_mem[64] = 32'hDEAD_BEEF;

        idle = mk(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        both = mk(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1, 4'h0, 32'h30, 32'h0, 1'b0, 1'b1);

        // First data read after reset, then response drain.
        vecs.push_back(mk(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 1'b1));
        vecs.push_back(idle);
        // Continuous contention: D,D,D,D,I,D,D,D,D,I with one embedded data write.
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1, (k == 2) ? 4'hF : 4'h0,
                              32'h20, 32'hCAFE_0002, (k == 4 || k == 9), !(k == 4 || k == 9)));
        vecs.push_back(idle);
        // Counter at limit clears when fetch drops its request.
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1'b1, 4'h0, 32'h14, 32'h0, 1'b0, 1'b1, 4'h0, 32'h24, 32'h0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h24, 32'h0, 1'b0, 1'b1));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1'b1, 4'h0, 32'h14, 32'h0, 1'b0, 1'b1, 4'h0, 32'h28, 32'h0,
                              (k == 4), (k != 4)));
        vecs.push_back(idle);
        // Write then fetch read of the same word, then a partial write and read back.
        vecs.push_back(mk(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4'hF, 32'h200, 32'h1234_5678, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4'h3, 32'h200, 32'hAABB_CCDD, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 1'b1));
        vecs.push_back(idle);
        // Flush squashes the fetch response but not a data grant in the same cycle.
        vecs.push_back(mk(1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h104, 32'h0, 1'b0, 1'b1));
        vecs.push_back(idle);
        // Flush during a grant cycle leaves that grant's response intact.
        vecs.push_back(mk(1'b1, 4'h0, 32'h104, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0));
        vecs.push_back(idle);
        // Fetch-side write acks with zero data; data reads it back.
        vecs.push_back(mk(1'b1, 4'hF, 32'h300, 32'h0BAD_F00D, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h300, 32'h0, 1'b0, 1'b1));
        vecs.push_back(idle);

        // Requests held during reset must not be granted.
        rst_n = 1'b0;
        drive(both);
        repeat (2) @(negedge clk);
        chk("rst i_gnt", {31'h0, i_gnt}, 32'h0);
        chk("rst d_gnt", {31'h0, d_gnt}, 32'h0);
        chk("rst sram_en", {31'h0, sram_en}, 32'h0);
        chk("rst i_rvalid", {31'h0, i_rvalid}, 32'h0);
        chk("rst d_rvalid", {31'h0, d_rvalid}, 32'h0);
        chk("rst d_rdata", d_rdata, 32'h0);
        @(posedge clk); #1;
        drive(idle);
        rst_n = 1'b1;

        foreach (vecs[n]) step(vecs[n]);

        // Reset between a data grant and its response drops the response and clears the counter.
        for (int k = 0; k < 3; k++) step(both);
        drive(both);
        @(negedge clk);
        check_resp(1'b0);
        check_grant(both);
        #1;
        rst_n = 1'b0;
        drive(idle);
        @(posedge clk); #1;
        drive(both);
        @(negedge clk);
        chk("midrst i_gnt", {31'h0, i_gnt}, 32'h0);
        chk("midrst d_gnt", {31'h0, d_gnt}, 32'h0);
        chk("midrst sram_en", {31'h0, sram_en}, 32'h0);
        chk("midrst d_rvalid", {31'h0, d_rvalid}, 32'h0);
        chk("midrst i_rvalid", {31'h0, i_rvalid}, 32'h0);
        sb.delete();
        #1;
        drive(idle);
        rst_n = 1'b1;
        @(posedge clk); #1;
        vec_no = 1000;
        step(both);
        step(idle);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
